// File: rtl/cost_rom_arbiter_pkg.sv
// Shared definitions for the job-assignment engine cost-ROM path:
// default index/cost widths, the pipeline tag type and the round-robin pick.
package jam_pkg;

    localparam int WB_DEF   = 3;
    localparam int JB_DEF   = 3;
    localparam int CB_DEF   = 7;
    localparam int NREQ_MAX = 4;
    localparam int PW       = 2;    // pointer width, enough for NREQ_MAX lanes

    typedef struct packed {
        logic                valid;
        logic [NREQ_MAX-1:0] lane;  // one-hot lane that owns this lookup
    } lane_tag_t;

    // One-hot grant for the first requesting lane found scanning
    // ptr, ptr+1, ... modulo nreq. Lanes at or above nreq are ignored.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input logic [PW-1:0]       ptr,
        input int                  nreq
    );
        logic [NREQ_MAX-1:0] g;
        logic [PW-1:0]       idx;
        g = '0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = PW'((int'(ptr) + k) % nreq);
            if (k < nreq && g == '0 && req[idx])
                g[idx] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/cost_rom_arbiter_if.sv
// Lane-side bundle of the cost-ROM arbiter: requests and indices in,
// grant and tagged return data out. Lanes use master, the arbiter slave.
interface cost_rom_arbiter_if
    import jam_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WB   = WB_DEF,
    parameter int JB   = JB_DEF,
    parameter int CB   = CB_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ*WB-1:0] req_w;
    logic [NREQ*JB-1:0] req_j;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvld;
    logic [CB-1:0]      rdata;

    modport master (output req, req_w, req_j, input gnt, rvld, rdata);
    modport slave  (input req, req_w, req_j, output gnt, rvld, rdata);
endinterface

// File: rtl/cost_rom_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks one requester starting at ptr
// and reports the pointer value to load if the grant is taken.
module rr_arbiter
    import jam_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   ptr_nxt
);
    logic [NREQ_MAX-1:0] req_x;
    logic [NREQ_MAX-1:0] pick;

    // Pick a lane and derive the pointer just past it; no grant when disabled.
    always_comb begin
        req_x = '0;
        req_x[NREQ-1:0] = req;
        pick = enable ? rr_pick(req_x, ptr, NREQ) : '0;
        gnt = pick[NREQ-1:0];
        ptr_nxt = ptr;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (pick[i])
                ptr_nxt = PW'((i + 1) % NREQ);
        end
    end
endmodule

// File: rtl/cost_rom_arbiter.sv
// Shares the single cost-ROM read port among NREQ lanes. One grant per
// cycle, address registered at grant, ROM data returned to the owning lane
// three cycles after its grant through a two-stage tag pipeline.
module cost_rom_arbiter
    import jam_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WB   = WB_DEF,
    parameter int JB   = JB_DEF,
    parameter int CB   = CB_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    cost_rom_arbiter_if.slave   lanes,
    output logic [WB-1:0]       W,
    output logic [JB-1:0]       J,
    input  logic [CB-1:0]       Cost,
    output logic                busy,
    output logic [15:0]         lookups
);
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_nxt;
    logic [NREQ-1:0]     gnt;
    logic [NREQ_MAX-1:0] gnt_x;
    logic [WB-1:0]       w_sel;
    logic [JB-1:0]       j_sel;
    lane_tag_t           s1;
    lane_tag_t           s2;
    logic [NREQ_MAX-1:0] rvld_x;
    logic [CB-1:0]       rdata_q;

    // Grant is gated by reset so no lane is taken while the block is held.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (lanes.req),
        .ptr     (ptr),
        .enable  (RST_N),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign lanes.gnt   = gnt;
    assign lanes.rvld  = rvld_x[NREQ-1:0];
    assign lanes.rdata = rdata_q;
    assign busy        = s1.valid | s2.valid | (|rvld_x);

    // Select the granted lane's indices and widen the grant to tag width.
    always_comb begin
        w_sel = '0;
        j_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_sel = lanes.req_w[i*WB +: WB];
                j_sel = lanes.req_j[i*JB +: JB];
            end
        end
        gnt_x = '0;
        gnt_x[NREQ-1:0] = gnt;
    end

    // Issue, tag pipeline and return registers; reset drops anything in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr     <= '0;
            W       <= '0;
            J       <= '0;
            s1      <= '0;
            s2      <= '0;
            rvld_x  <= '0;
            rdata_q <= '0;
            lookups <= '0;
        end else begin
            if (|gnt) begin
                ptr     <= ptr_nxt;
                W       <= w_sel;
                J       <= j_sel;
                lookups <= lookups + 16'd1;
            end
            s1 <= '{valid: |gnt, lane: gnt_x};
            s2 <= s1;
            if (s2.valid) begin
                rvld_x  <= s2.lane;
                rdata_q <= Cost;
            end else begin
                rvld_x  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Bench for cost_rom_arbiter: a 2-lane instance driven from a vector table
// with a return scoreboard, and a 4-lane instance for pointer rotation and
// lookup-counter wrap.
module tb_cost_rom_arbiter;
    import jam_pkg::*;

    localparam int WB = 3;
    localparam int JB = 3;
    localparam int CB = 7;
    localparam int NV = 33;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    cost_rom_arbiter_if #(.NREQ(2)) if2 ();
    cost_rom_arbiter_if #(.NREQ(4)) if4 ();

    logic [WB-1:0] W2, W4;
    logic [JB-1:0] J2, J4;
    logic [CB-1:0] cost2, cost4;
    logic          busy2, busy4;
    logic [15:0]   lk2, lk4;

    cost_rom_arbiter #(.NREQ(2)) u2 (
        .CLK(CLK), .RST_N(RST_N), .lanes(if2), .W(W2), .J(J2),
        .Cost(cost2), .busy(busy2), .lookups(lk2)
    );
    cost_rom_arbiter #(.NREQ(4)) u4 (
        .CLK(CLK), .RST_N(RST_N), .lanes(if4), .W(W4), .J(J4),
        .Cost(cost4), .busy(busy4), .lookups(lk4)
    );

    // Synchronous ROM model: samples W/J at the edge, data valid next cycle.
    logic [CB-1:0] rom [64];
    always @(posedge CLK) begin
        cost2 <= rom[{W2, J2}];
        cost4 <= rom[{W4, J4}];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the 2-lane instance.
    typedef struct {
        logic [1:0]    lane;
        logic [CB-1:0] data;
        int            due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_new;
    exp_t        e_old;
    int          cyc = 0;
    logic [15:0] lk_m = '0;
    logic [2:0]  hist = '0;
    logic [5:0]  addr;

    always @(negedge CLK) begin
        cyc++;
        if (!RST_N) begin
            sb.delete();
            lk_m = '0;
            hist = '0;
            check("rst_gnt2", 32'(if2.gnt), 32'd0);
            check("rst_rvld2", 32'(if2.rvld), 32'd0);
        end else begin
            check("busy2", 32'(busy2), 32'(|hist));
            check("lookups2", 32'(lk2), 32'(lk_m));
            if (if2.rvld != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rvld2_unexpected", 32'(if2.rvld), 32'd0);
                end else begin
                    e_old = sb.pop_front();
                    check("rvld2_lane", 32'(if2.rvld), 32'(e_old.lane));
                    check("rdata2", 32'(if2.rdata), 32'(e_old.data));
                    check("rvld2_latency", 32'(cyc), 32'(e_old.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("rvld2_missing", 32'(if2.rvld), 32'(sb[0].lane));
                void'(sb.pop_front());
            end
            if (if2.gnt != 2'b00) begin
                addr = if2.gnt[1] ? {if2.req_w[5:3], if2.req_j[5:3]}
                                  : {if2.req_w[2:0], if2.req_j[2:0]};
                e_new.lane = if2.gnt;
                e_new.data = rom[addr];
                e_new.due  = cyc + 3;
                sb.push_back(e_new);
                lk_m = lk_m + 16'd1;
            end
            hist = {hist[1:0], |if2.gnt};
        end
    end

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [2:0] w0, j0, w1, j1;
        logic [1:0] exp_gnt;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic [1:0] q,
                                input logic [2:0] w0, input logic [2:0] j0,
                                input logic [2:0] w1, input logic [2:0] j1,
                                input logic [1:0] g);
        vec_t v;
        v.rst_n = r; v.req = q;
        v.w0 = w0; v.j0 = j0; v.w1 = w1; v.j1 = j1;
        v.exp_gnt = g;
        return v;
    endfunction

    int   cnt0, cnt1;
    logic g02;

    initial begin
        RST_N     = 1'b0;
        if2.req   = '0;
        if2.req_w = '0;
        if2.req_j = '0;
        if4.req   = 4'b1111;
        if4.req_w = 12'hFFF;
        if4.req_j = 12'h924;
        for (int a = 0; a < 64; a++) rom[a] = CB'((a * 37 + 5) % 128);
        rom[29] = 7'd42;

        for (int i = 0; i < NV; i++) vecs[i] = mk(1, 2'b00, 0, 0, 0, 0, 2'b00);
        vecs[0]  = mk(0, 2'b11, 0, 0, 0, 0, 2'b00);
        vecs[1]  = mk(1, 2'b01, 3, 5, 0, 0, 2'b01);
        vecs[6]  = mk(0, 2'b00, 0, 0, 0, 0, 2'b00);
        for (int i = 7; i < 15; i++)
            vecs[i] = mk(1, 2'b11, 3'(i % 8), 3'((i + 3) % 8), 3'((i * 3) % 8),
                         3'(7 - (i % 8)), ((i - 7) % 2 == 0) ? 2'b01 : 2'b10);
        vecs[15] = mk(1, 2'b10, 0, 0, 0, 0, 2'b10);
        vecs[16] = mk(1, 2'b10, 0, 0, 1, 1, 2'b10);
        vecs[17] = mk(1, 2'b10, 0, 0, 2, 2, 2'b10);
        vecs[18] = mk(1, 2'b10, 0, 0, 7, 7, 2'b10);
        vecs[24] = mk(0, 2'b00, 0, 0, 0, 0, 2'b00);
        vecs[25] = mk(1, 2'b01, 4, 4, 0, 0, 2'b01);
        vecs[26] = mk(1, 2'b01, 6, 1, 0, 0, 2'b01);
        vecs[27] = mk(0, 2'b01, 6, 1, 0, 0, 2'b00);
        vecs[28] = mk(1, 2'b11, 5, 2, 1, 6, 2'b01);

        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < NV; i++) begin
            @(posedge CLK); #1;
            RST_N     = vecs[i].rst_n;
            if2.req   = vecs[i].req;
            if2.req_w = {vecs[i].w1, vecs[i].w0};
            if2.req_j = {vecs[i].j1, vecs[i].j0};
            @(negedge CLK);
            check($sformatf("gnt_row%0d", i), 32'(if2.gnt), 32'(vecs[i].exp_gnt));
            case (i)
                0: begin
                    check("rst_gnt4", 32'(if4.gnt), 32'd0);
                    check("rst_W", 32'(W2), 32'd0);
                    check("rst_J", 32'(J2), 32'd0);
                    check("rst_rdata", 32'(if2.rdata), 32'd0);
                    check("rst_busy", 32'(busy2), 32'd0);
                    check("rst_lookups", 32'(lk2), 32'd0);
                end
                2: begin
                    check("issue_W", 32'(W2), 32'd3);
                    check("issue_J", 32'(J2), 32'd5);
                    check("lookups_one", 32'(lk2), 32'd1);
                end
                4: begin
                    check("single_rvld", 32'(if2.rvld), 32'b01);
                    check("single_rdata", 32'(if2.rdata), 32'd42);
                end
                15: begin
                    check("alt_lookups", 32'(lk2), 32'd8);
                    check("alt_cnt0", 32'(cnt0), 32'd4);
                    check("alt_cnt1", 32'(cnt1), 32'd4);
                end
                21: begin
                    check("b2b_last_rvld", 32'(if2.rvld), 32'b10);
                    check("b2b_last_cost", 32'(if2.rdata), 32'(rom[63]));
                    check("b2b_busy_hi", 32'(busy2), 32'd1);
                end
                22: check("b2b_busy_drop", 32'(busy2), 32'd0);
                28: begin
                    check("midrst_W", 32'(W2), 32'd0);
                    check("midrst_J", 32'(J2), 32'd0);
                    check("midrst_lookups", 32'(lk2), 32'd0);
                    check("midrst_rvld_a", 32'(if2.rvld), 32'd0);
                end
                29: check("midrst_rvld_b", 32'(if2.rvld), 32'd0);
                default: ;
            endcase
            if (!vecs[i].rst_n) begin
                cnt0 = 0;
                cnt1 = 0;
            end else begin
                cnt0 += int'(if2.gnt[0]);
                cnt1 += int'(if2.gnt[1]);
            end
        end

        // Four lanes, only 1 and 3 requesting: rotation and counter wrap.
        @(posedge CLK); #1;
        RST_N   = 1'b0;
        if2.req = '0;
        if4.req = '0;
        @(posedge CLK); #1;
        RST_N   = 1'b1;
        if4.req = 4'b1010;
        g02 = 1'b0;
        for (int k = 0; k <= 65536; k++) begin
            @(negedge CLK);
            if (k < 8)
                check($sformatf("rr4_gnt%0d", k), 32'(if4.gnt), (k % 2 == 0) ? 32'b0010 : 32'b1000);
            if (k == 4)     check("lookups4_four", 32'(lk4), 32'd4);
            if (k == 65535) check("lookups4_max", 32'(lk4), 32'hFFFF);
            if (k == 65536) check("lookups4_wrap", 32'(lk4), 32'd0);
            g02 = g02 | if4.gnt[0] | if4.gnt[2];
        end
        check("rr4_lanes02_idle", 32'(g02), 32'd0);

        @(posedge CLK); #1;
        if4.req = '0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("busy4_drained", 32'(busy4), 32'd0);
        check("sb2_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cost_rom_arbiter.md
# cost_rom_arbiter

Round-robin scheduler sharing the single cost-ROM read port (W/J address out, Cost in) among NREQ evaluation lanes of the job-assignment engine. Each lane posts a worker/job lookup. The arbiter grants one lane per cycle and drives the ROM address. It then returns the ROM data to the granted lane with a tagged valid pulse, fully pipelined at one lookup per cycle.

## Interface
- NREQ, 2: number of requesting lanes (2..4).
- WB, 3: worker index width.
- JB, 3: job index width.
- CB, 7: cost width.
- CLK  in  1  clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req  in  NREQ  per-lane lookup request; level, held until granted.
- req_w  in  NREQ*WB  per-lane worker index, lane i at [i*WB +: WB].
- req_j  in  NREQ*JB  per-lane job index, same packing.
- gnt  out  NREQ  one-hot combinational grant, same cycle as req.
- W  out  WB  registered worker address to the cost ROM.
- J  out  JB  registered job address to the cost ROM.
- Cost  in  CB  ROM data, valid the cycle after the ROM samples W/J.
- rvld  out  NREQ  one-hot return-valid pulse, registered.
- rdata  out  CB  returned cost, registered, shared by all lanes.
- busy  out  1  any lookup in flight in the pipeline.
- lookups  out  16  total granted lookups since reset; wraps at 16'hFFFF→0.

## Operation
- Arbitration
  - Round-robin with a pointer ptr (index of the highest-priority lane).
  - gnt = first lane with req=1, scanning ptr, ptr+1, … mod NREQ.
  - At most one gnt bit is set. gnt=0 when no req is set.
  - On a grant to lane g, ptr ← (g+1) mod NREQ. With no grant, ptr holds.
- A lane sees gnt[i]=1 in the cycle its request is taken. In the next cycle it either drops req or presents a new index.
- Issue: on a grant, W/J ← the granted lane's req_w/req_j at the clock edge. With no grant, W/J hold their value.
- Tag pipeline: two stages of {valid, lane one-hot}.
  - s1 loads at grant (address stage).
  - s2 ← s1 (ROM sample stage).
  - When s2.valid: rvld ← s2.lane and rdata ← Cost; otherwise rvld ← 0 and rdata holds.
- busy = s1.valid | s2.valid | any rvld bit.
- lookups increments by 1 on every grant.
- The arbiter applies no backpressure. Lanes must accept rvld unconditionally.
- Reset (any time, including mid-pipeline)
  - ptr=0, W=0, J=0, s1/s2 cleared, rvld=0, rdata=0, busy=0, lookups=0.
  - In-flight lookups are discarded with no return pulse.
  - gnt is 0 while RST_N=0, regardless of req.

## Timing
- Cycle t: req[i]=1 and gnt[i]=1 (combinational).
- Edge end of t: W/J are registered and visible in t+1.
- Edge end of t+1: the ROM samples W/J. Cost is valid in t+2.
- Edge end of t+2: rdata/rvld are registered and visible in t+3.
- Grant-to-rvld latency: 3 cycles.
- Throughput: 1 lookup per cycle. Back-to-back grants produce back-to-back rvld in grant order.
- When all NREQ lanes request continuously, each lane is granted exactly once every NREQ cycles.

## Structure
- Shared package jam_pkg holds:
  - the WB/JB/CB defaults;
  - a lane_tag_t struct {valid, one-hot lane};
  - a function rr_pick(req, ptr) returning the one-hot grant.
- Sub-module rr_arbiter (req, ptr → gnt, next ptr) is combinational and reusable. The arbiter top owns all registers.

## Test plan
- Single lane 0, req_w=3, req_j=5, ROM[3*8+5]=42 → gnt[0] in cycle 0; W=3, J=5 in cycle 1; rvld=2'b01, rdata=42 in cycle 3; lookups=1.
- Both lanes requesting continuously from reset for 8 cycles → gnt alternates 01,10,01,…; 4 grants each; rvld follows the same pattern 3 cycles later; lookups=8.
- Lane 1 only, 4 back-to-back lookups (W/J = 0/0, 1/1, 2/2, 7/7) → 4 consecutive rvld=2'b10 with costs ROM[0], ROM[9], ROM[18], ROM[63] in order; busy drops 1 cycle after the last rvld.
- NREQ=4, lanes 1 and 3 requesting continuously, ptr=0 after reset → grants go 1,3,1,3; lanes 0 and 2 are never granted.
- Assert RST_N=0 for one cycle while 2 lookups are in flight → no rvld afterwards; W=J=0; lookups=0; the next grant goes to the lowest requesting lane.
- Drive lookups to 16'hFFFF (force or long run), then grant once → lookups=0.
